// File: rtl/uart_rx_axis_packer_if.sv
// AXI-Stream byte channel between the UART packer and its consumer.
interface uart_rx_axis_packer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             last;
    logic             ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/uart_rx_axis_packer.sv
// Packs UART receiver byte strobes into a framed AXI-Stream; one byte is held back
// so tlast can be attached once the packet end (idle gap or MAX_LEN) is known.
module uart_rx_axis_packer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned MAX_LEN    = 32,
    parameter int unsigned CLK_RATE   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned IDLE_CHARS = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [WIDTH-1:0]             i_rx_data,
    input  logic                         i_rx_valid,
    input  logic                         i_parity_error,
    uart_rx_axis_packer_if.master        m_axis,
    input  logic                         i_clr_status,
    output logic                         o_overflow,
    output logic [7:0]                   o_err_cnt,
    output logic [$clog2(DEPTH):0]       o_fifo_count
);
    localparam int unsigned BIT_CYC = CLK_RATE / BAUD;
    localparam int unsigned T_IDLE  = IDLE_CHARS * 10 * BIT_CYC;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned TW      = $clog2(T_IDLE + 1);
    localparam int unsigned LW      = $clog2(MAX_LEN + 1);

    localparam logic [AW:0]    FULL     = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0]  TMR_LAST = TW'(T_IDLE - 1);
    localparam logic [LW-1:0]  LEN_MAX  = LW'(MAX_LEN);
    localparam logic [LW-1:0]  LEN_ONE  = LW'(1);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_HELD  = 1'b1;

    logic [0:0]       r_state, w_state_d;
    logic [WIDTH-1:0] r_hold, w_hold_d;
    logic [TW-1:0]    r_timer, w_timer_d;
    logic [LW-1:0]    r_pkt_len, w_pkt_len_d;
    logic             w_accept, w_perr;
    logic             w_push, w_push_last, w_push_ok, w_pop;

    logic [WIDTH:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow, w_overflow_d;
    logic [7:0]       r_err_cnt, w_err_cnt_d;

    assign w_accept = i_rx_valid & ~i_parity_error;
    assign w_perr   = i_rx_valid & i_parity_error;

    always_comb begin
        w_state_d   = r_state;
        w_hold_d    = r_hold;
        w_timer_d   = r_timer;
        w_pkt_len_d = r_pkt_len;
        w_push      = 1'b0;
        w_push_last = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_hold_d    = i_rx_data;
                    w_timer_d   = '0;
                    w_pkt_len_d = r_pkt_len + LEN_ONE;
                    w_state_d   = S_HELD;
                end
            end
            S_HELD: begin
                if (r_pkt_len == LEN_MAX) begin
                    // Held byte completes the packet; a byte arriving now starts the next one.
                    w_push      = 1'b1;
                    w_push_last = 1'b1;
                    if (w_accept) begin
                        w_hold_d    = i_rx_data;
                        w_timer_d   = '0;
                        w_pkt_len_d = LEN_ONE;
                    end else begin
                        w_pkt_len_d = '0;
                        w_state_d   = S_EMPTY;
                    end
                end else if (w_accept) begin
                    w_push      = 1'b1;
                    w_hold_d    = i_rx_data;
                    w_timer_d   = '0;
                    w_pkt_len_d = r_pkt_len + LEN_ONE;
                end else if (w_perr) begin
                    w_timer_d = '0;
                end else if (r_timer == TMR_LAST) begin
                    w_push      = 1'b1;
                    w_push_last = 1'b1;
                    w_pkt_len_d = '0;
                    w_state_d   = S_EMPTY;
                end else begin
                    w_timer_d = r_timer + TW'(1);
                end
            end
            default: w_state_d = S_EMPTY;
        endcase
    end

    assign w_pop     = (r_count != '0) & m_axis.ready;
    assign w_push_ok = w_push & ((r_count < FULL) | w_pop);

    always_comb begin
        w_overflow_d = i_clr_status ? 1'b0 : r_overflow;
        if (w_push && !w_push_ok) w_overflow_d = 1'b1;
        w_err_cnt_d = i_clr_status ? 8'd0 : r_err_cnt;
        if (w_perr && w_err_cnt_d != 8'hFF) w_err_cnt_d = w_err_cnt_d + 8'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_EMPTY;
            r_hold     <= '0;
            r_timer    <= '0;
            r_pkt_len  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else begin
            r_state    <= w_state_d;
            r_hold     <= w_hold_d;
            r_timer    <= w_timer_d;
            r_pkt_len  <= w_pkt_len_d;
            r_overflow <= w_overflow_d;
            r_err_cnt  <= w_err_cnt_d;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= {w_push_last, r_hold};
    end

    // Head entry is masked so the stream reads zero whenever the FIFO is empty.
    assign m_axis.valid  = (r_count != '0);
    assign m_axis.data   = m_axis.valid ? r_mem[r_rd_ptr][WIDTH-1:0] : '0;
    assign m_axis.last   = m_axis.valid ? r_mem[r_rd_ptr][WIDTH] : 1'b0;
    assign o_overflow    = r_overflow;
    assign o_err_cnt     = r_err_cnt;
    assign o_fifo_count  = r_count;
endmodule

// File: tb/tb_uart_rx_axis_packer.sv
// Directed bench for uart_rx_axis_packer: expected beats are queued as bytes are driven
// and popped by a monitor on each accepted stream beat.
module tb_uart_rx_axis_packer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_error;
    logic       clr_status;
    logic       overflow;
    logic [7:0] err_cnt;
    logic [4:0] fifo_count;

    int checks = 0;
    int failures = 0;
    int n_out = 0;
    logic [8:0] exp_q[$];

    uart_rx_axis_packer_if #(.WIDTH(8)) m_if ();

    uart_rx_axis_packer dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rx_data      (rx_data),
        .i_rx_valid     (rx_valid),
        .i_parity_error (parity_error),
        .m_axis         (m_if),
        .i_clr_status   (clr_status),
        .o_overflow     (overflow),
        .o_err_cnt      (err_cnt),
        .o_fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beats are sampled mid-cycle; the handshake completes on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && m_if.valid && m_if.ready) begin
            logic [8:0] e;
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat_data", 32'(m_if.data), 32'(e[7:0]));
                check("beat_last", 32'(m_if.last), 32'(e[8]));
            end
            n_out++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic pe);
        rx_data      = d;
        parity_error = pe;
        rx_valid     = 1'b1;
        tick(1);
        rx_valid     = 1'b0;
        parity_error = 1'b0;
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick(1);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        parity_error = 1'b0;
        clr_status = 1'b0;
        m_if.ready = 1'b1;
        #2;
        check("rst_valid", 32'(m_if.valid), 32'd0);
        check("rst_last", 32'(m_if.last), 32'd0);
        check("rst_data", 32'(m_if.data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Slow bytes closed by idle; check idle-close latency of the last byte.
        expect_beat(8'h41, 1'b0);
        expect_beat(8'h42, 1'b0);
        expect_beat(8'h43, 1'b1);
        send(8'h41, 1'b0);
        tick(4339);
        send(8'h42, 1'b0);
        tick(4339);
        send(8'h43, 1'b0);
        tick(1);
        lat = 2;
        while (!m_if.valid && lat < 10000) begin
            tick(1);
            lat++;
        end
        check("idle_latency", 32'(lat), 32'd8681);
        wait_drain("drain_t1", 100);

        // Back-to-back bytes split at MAX_LEN, remainder closed by idle.
        for (int i = 0; i < 40; i++) begin
            expect_beat(8'(i), (i == 31) || (i == 39));
            send(8'(i), 1'b0);
        end
        wait_drain("drain_t2", 10000);

        // Overflow with a stalled sink.
        m_if.ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            if (i <= 16) expect_beat(8'(8'h60 + i), 1'b0);
            send(8'(8'h60 + i), 1'b0);
        end
        check("full_count", 32'(fifo_count), 32'd16);
        check("ovf_before_drop", 32'(overflow), 32'd0);
        send(8'h72, 1'b0);
        check("ovf_after_drop", 32'(overflow), 32'd1);
        send(8'h73, 1'b0);
        send(8'h74, 1'b0);
        expect_beat(8'h74, 1'b1);
        check("full_count_hold", 32'(fifo_count), 32'd16);
        m_if.ready = 1'b1;
        wait_drain("drain_t3", 10000);
        check("ovf_sticky", 32'(overflow), 32'd1);
        clr_status = 1'b1;
        tick(1);
        clr_status = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Parity-error byte dropped and counted; clear collides with a new error.
        expect_beat(8'h10, 1'b0);
        expect_beat(8'h20, 1'b1);
        send(8'h10, 1'b0);
        tick(3);
        send(8'h55, 1'b1);
        tick(3);
        send(8'h20, 1'b0);
        check("err_one", 32'(err_cnt), 32'd1);
        tick(3);
        clr_status = 1'b1;
        send(8'h56, 1'b1);
        clr_status = 1'b0;
        check("err_clr_collide", 32'(err_cnt), 32'd1);
        clr_status = 1'b1;
        tick(1);
        clr_status = 1'b0;
        check("err_cleared", 32'(err_cnt), 32'd0);
        wait_drain("drain_t4", 10000);

        // Stall stability, then simultaneous push/pop.
        m_if.ready = 1'b0;
        expect_beat(8'hA0, 1'b0);
        expect_beat(8'hA1, 1'b0);
        expect_beat(8'hA2, 1'b0);
        expect_beat(8'hA3, 1'b0);
        expect_beat(8'hA4, 1'b1);
        send(8'hA0, 1'b0);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("stall_data", 32'(m_if.data), 32'hA0);
            check("stall_last", 32'(m_if.last), 32'd0);
            tick(1);
        end
        check("stall_count", 32'(fifo_count), 32'd2);
        m_if.ready = 1'b1;
        send(8'hA3, 1'b0);
        check("pushpop_count1", 32'(fifo_count), 32'd2);
        m_if.ready = 1'b0;
        tick(1);
        m_if.ready = 1'b1;
        send(8'hA4, 1'b0);
        check("pushpop_count2", 32'(fifo_count), 32'd2);
        wait_drain("drain_t5", 10000);

        // Reset mid-packet with 3 buffered and 1 held.
        m_if.ready = 1'b0;
        send(8'h5A, 1'b1);
        send(8'hB0, 1'b0);
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        send(8'hB3, 1'b0);
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        check("pre_rst_err", 32'(err_cnt), 32'd1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_valid", 32'(m_if.valid), 32'd0);
        check("mid_rst_data", 32'(m_if.data), 32'd0);
        tick(1);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_err", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        m_if.ready = 1'b1;
        tick(2);
        check("post_rst_valid", 32'(m_if.valid), 32'd0);
        expect_beat(8'h70, 1'b0);
        expect_beat(8'h71, 1'b1);
        send(8'h70, 1'b0);
        send(8'h71, 1'b0);
        wait_drain("drain_t6", 10000);
        tick(5);
        check("total_beats", 32'(n_out), 32'd69);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
